// File: rtl/updown_sweep_controller.sv
// updown_sweep_controller: bounded triangle-sweep up/down counter with endpoint dwell, sweep count and abort
module updown_sweep_controller #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               upordown,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
);
    typedef enum logic [2:0] {IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [DWELL_W-1:0] dwell_q, tmr;
    logic [SWEEP_W-1:0] num_q, sweep_inc;
    logic               accept, reject, at_hi, at_lo, last, tmr_end, no_dwell;
    // shared decode of start acceptance, endpoint hits and final-sweep detection
    always_comb begin
        accept    = (state == IDLE) && start && !abort && (lo < hi);
        reject    = (state == IDLE) && start && !abort && (lo >= hi);
        at_hi     = count == hi_q;
        at_lo     = count == lo_q;
        sweep_inc = sweep_cnt + SWEEP_W'(1);
        last      = (num_q != '0) && (sweep_inc == num_q);
        tmr_end   = tmr == DWELL_W'(1);
        no_dwell  = dwell_q == '0;
    end
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end
    // next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state;
        if (abort) state_d = IDLE;
        else begin
            case (state)
                IDLE:     state_d = accept ? UP : IDLE;
                UP:       state_d = !at_hi ? UP : (no_dwell ? DOWN : DWELL_HI);
                DWELL_HI: state_d = tmr_end ? DOWN : DWELL_HI;
                DOWN:     state_d = !at_lo ? DOWN : (last ? DONE : (no_dwell ? UP : DWELL_LO));
                DWELL_LO: state_d = tmr_end ? UP : DWELL_LO;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end
    // outputs decoded from registered state
    always_comb begin
        busy = (state == UP) || (state == DWELL_HI) || (state == DOWN) || (state == DWELL_LO);
        done = state == DONE;
    end
    // counter, direction, sweep tally, dwell timer and latched configuration; abort freezes all of them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            upordown  <= 1'b1;
            err       <= 1'b0;
            sweep_cnt <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            dwell_q   <= '0;
            num_q     <= '0;
            tmr       <= '0;
        end else begin
            err <= reject;
            if (!abort) begin
                case (state)
                    IDLE: if (accept) begin
                        lo_q      <= lo;
                        hi_q      <= hi;
                        dwell_q   <= dwell;
                        num_q     <= num_sweeps;
                        sweep_cnt <= '0;
                        count     <= lo;
                        upordown  <= 1'b1;
                    end
                    UP: begin
                        if (!at_hi) count <= count + WIDTH'(1);
                        else if (!no_dwell) tmr <= dwell_q;
                        else begin
                            count    <= hi_q - WIDTH'(1);
                            upordown <= 1'b0;
                        end
                    end
                    DWELL_HI: begin
                        tmr <= tmr - DWELL_W'(1);
                        if (tmr_end) begin
                            count    <= hi_q - WIDTH'(1);
                            upordown <= 1'b0;
                        end
                    end
                    DOWN: begin
                        if (!at_lo) count <= count - WIDTH'(1);
                        else begin
                            sweep_cnt <= sweep_inc;
                            if (!last && no_dwell) begin
                                count    <= lo_q + WIDTH'(1);
                                upordown <= 1'b1;
                            end else if (!last) tmr <= dwell_q;
                        end
                    end
                    DWELL_LO: begin
                        tmr <= tmr - DWELL_W'(1);
                        if (tmr_end) begin
                            count    <= lo_q + WIDTH'(1);
                            upordown <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_updown_sweep_controller.sv
// tb_updown_sweep_controller: scoreboard bench; expected per-cycle records are queued, monitor pops on every active cycle
module tb_updown_sweep_controller;
    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0] lo = '0, hi = '0, dwell = '0;
    logic [7:0] num_sweeps = '0;
    logic [3:0] count;
    logic       upordown, busy, done, err;
    logic [7:0] sweep_cnt;

    typedef struct packed {
        logic [3:0] c;
        logic       d;
        logic       b;
        logic       dn;
        logic       e;
        logic [7:0] s;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_a, mon_e;
    int   checks = 0, errors = 0, rec_idx = 0;

    updown_sweep_controller #(.WIDTH(4), .DWELL_W(4), .SWEEP_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .dwell(dwell), .num_sweeps(num_sweeps),
        .count(count), .upordown(upordown), .busy(busy), .done(done),
        .err(err), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // monitor: any cycle with busy, done or err is an output record to be matched against the queue
    always @(negedge clk) begin
        if (reset && (busy || done || err)) begin
            mon_a = {count, upordown, busy, done, err, sweep_cnt};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("rec%0d{cnt,dir,busy,done,err,swp}", rec_idx), mon_a, mon_e);
            end
            rec_idx++;
        end
    end

    task automatic push(input logic [3:0] c, input logic d, input logic b, input logic dn,
                        input logic e, input logic [7:0] s);
        exp_q.push_back({c, d, b, dn, e, s});
    endtask

    task automatic up(input int f, input int t, input logic [7:0] s);
        for (int v = f; v <= t; v++) push(4'(v), 1'b1, 1'b1, 1'b0, 1'b0, s);
    endtask

    task automatic down(input int f, input int t, input logic [7:0] s);
        for (int v = f; v >= t; v--) push(4'(v), 1'b0, 1'b1, 1'b0, 1'b0, s);
    endtask

    task automatic go(input logic [3:0] l, input logic [3:0] h, input logic [3:0] dw, input logic [7:0] n);
        lo = l; hi = h; dwell = dw; num_sweeps = n; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_count", count, 0);
        check("rst_dir", upordown, 1);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_sweep", sweep_cnt, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        up(2, 5, 0); down(4, 2, 0); up(3, 5, 1); down(4, 2, 1); push(2, 0, 0, 1, 0, 2);
        go(2, 5, 0, 2);
        drain("basic");
        check("basic_idle_busy", busy, 0);

        up(0, 3, 0); push(3, 1, 1, 0, 0, 0); push(3, 1, 1, 0, 0, 0); down(2, 0, 0); push(0, 0, 0, 1, 0, 1);
        go(0, 3, 2, 1);
        drain("dwell");

        push(0, 0, 0, 0, 1, 1);
        go(7, 7, 0, 0);
        drain("err_equal");
        push(0, 0, 0, 0, 1, 1);
        go(9, 3, 0, 0);
        drain("err_inverted");
        check("err_busy", busy, 0);
        check("err_count", count, 0);

        up(1, 3, 0); down(2, 1, 0); push(1, 0, 0, 1, 0, 1);
        go(1, 3, 0, 1);
        @(posedge clk); @(posedge clk); #1 lo = 0; hi = 9; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        drain("ignored_busy");
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("abort_start_idle_busy", busy, 0);
        check("abort_start_idle_count", count, 1);

        up(0, 15, 0); down(14, 0, 0); up(1, 15, 1); down(14, 0, 1); up(1, 15, 2); down(14, 9, 2);
        go(0, 15, 0, 0);
        repeat (81) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_count", count, 9);
        check("abort_dir", upordown, 0);
        check("abort_sweep", sweep_cnt, 2);
        check("abort_done", done, 0);
        drain("continuous");

        up(2, 4, 0);
        go(2, 8, 0, 0);
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        check("pre_reset_count", count, 4);
        reset = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_dir", upordown, 1);
        check("async_rst_busy", busy, 0);
        #1 reset = 1'b1;
        drain("reset_mid");
        check("post_reset_busy", busy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
